// File: rtl/reg_dump.sv
// Debug read-out engine: stalls the core, walks the register file in ascending
// order and streams each value on a valid/ready port. Optional: REG_DUMP_SKIP_X0_EN.
module reg_dump #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [$clog2(NREGS)-1:0]   rf_addr,
    input  logic [XLEN-1:0]            rf_data,
    output logic                       core_stall,
    output logic [XLEN-1:0]            dout,
    output logic [$clog2(NREGS)-1:0]   dout_idx,
    output logic                       dout_last,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       done
);

    localparam int AW = $clog2(NREGS);

`ifdef REG_DUMP_SKIP_X0_EN
    localparam logic [AW:0] FIRST_PTR = (AW+1)'(1);
`else
    localparam logic [AW:0] FIRST_PTR = (AW+1)'(0);
`endif
    localparam logic [AW:0] LAST_PTR  = (AW+1)'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [AW:0]         ptr_r;
    logic [AW:0]         ptr_nxt_s;
    logic [XLEN-1:0]     dout_r;
    logic [XLEN-1:0]     dout_nxt_s;
    logic [AW-1:0]       dout_idx_r;
    logic [AW-1:0]       dout_idx_nxt_s;
    logic                dout_last_r;
    logic                dout_last_nxt_s;
    logic                dout_valid_r;
    logic                dout_valid_nxt_s;
    logic                in_range_s;
    logic                accept_s;
    logic                load_s;
    logic [XLEN-1:0]     rd_word_s;

    // Pointer stays in range while its top bit is clear (NREGS is a power of two)
    assign in_range_s = ~ptr_r[AW];
    assign accept_s   = dout_valid_r & dout_ready;
    // x0 is architecturally zero regardless of what the read port returns
    assign rd_word_s  = (ptr_r[AW-1:0] == {AW{1'b0}}) ? {XLEN{1'b0}} : rf_data;

    // Next-state, pointer and output-word update logic
    always_comb begin
        state_nxt_s      = state_r;
        ptr_nxt_s        = ptr_r;
        dout_nxt_s       = dout_r;
        dout_idx_nxt_s   = dout_idx_r;
        dout_last_nxt_s  = dout_last_r;
        dout_valid_nxt_s = dout_valid_r;
        load_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    ptr_nxt_s   = FIRST_PTR;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                load_s = in_range_s & (~dout_valid_r | dout_ready);
                if (accept_s && dout_last_r) begin
                    dout_valid_nxt_s = 1'b0;
                    state_nxt_s      = ST_DONE;
                end else if (load_s) begin
                    dout_nxt_s       = rd_word_s;
                    dout_idx_nxt_s   = ptr_r[AW-1:0];
                    dout_last_nxt_s  = (ptr_r == LAST_PTR);
                    dout_valid_nxt_s = 1'b1;
                    ptr_nxt_s        = ptr_r + (AW+1)'(1);
                end else if (accept_s) begin
                    dout_valid_nxt_s = 1'b0;
                end else begin
                    dout_valid_nxt_s = dout_valid_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                dout_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any dump in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {(AW+1){1'b0}};
            dout_r       <= {XLEN{1'b0}};
            dout_idx_r   <= {AW{1'b0}};
            dout_last_r  <= 1'b0;
            dout_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_idx_r   <= dout_idx_nxt_s;
            dout_last_r  <= dout_last_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
        end
    end

    assign core_stall = (state_r == ST_RUN);
    assign done       = (state_r == ST_DONE);
    assign rf_addr    = (state_r == ST_RUN) ? ptr_r[AW-1:0] : {AW{1'b0}};
    assign dout       = dout_r;
    assign dout_idx   = dout_idx_r;
    assign dout_last  = dout_last_r;
    assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: register-file model, random backpressure,
// reference sequence computed from the dump rules.
`timescale 1ns/1ps
module tb_reg_dump;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
`ifdef REG_DUMP_SKIP_X0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NW   = NREGS - FIRST;
    localparam int MAXC = 400;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            dout_ready = 1'b0;
    logic [4:0]      rf_addr;
    logic [4:0]      dout_idx;
    logic [31:0]     rf_data;
    logic [31:0]     dout;
    logic            core_stall, dout_last, dout_valid, done;

    logic [31:0]     regs [0:31];
    assign rf_data = regs[rf_addr];

    always #5 clk = ~clk;

    reg_dump #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
        .core_stall(core_stall), .dout(dout), .dout_idx(dout_idx), .dout_last(dout_last),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .done(done)
    );

    int checks = 0;
    int errors = 0;
    bit rpat [0:MAXC-1];
    int          obs_idx[$];
    logic [31:0] obs_data[$];
    bit          obs_last[$];
    int done_cyc, done_cnt, stall_bad, hold_bad;

    // Expected data of the k-th emitted word
    function automatic logic [31:0] exp_data(input int k);
        int r = FIRST + k;
        return (r == 0) ? 32'h0 : regs[r];
    endfunction

    // Cycle (counted from the start edge) in which done is expected
    function automatic int exp_done();
        int acc = 0;
        for (int c = 1; c < MAXC; c++) begin
            if (rpat[c]) acc++;
            if (acc == NW) return c + 1;
        end
        return -2;
    endfunction

    task automatic set_pat(input int mode);
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0: rpat[c] = 1'b1;
                1: rpat[c] = (c == 0) || (((c - 1) % 3) == 0);
                default: rpat[c] = ($urandom_range(0, 99) < 55);
            endcase
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs cycles after the start edge, recording accepted words and protocol violations
    task automatic drain(input int abort_idx, input int start_at);
        bit hold_v = 1'b0;
        logic [31:0] h_d = 32'h0;
        logic [4:0]  h_i = 5'h0;
        logic        h_l = 1'b0;
        obs_idx.delete(); obs_data.delete(); obs_last.delete();
        done_cyc = -1; done_cnt = 0; stall_bad = 0; hold_bad = 0;
        for (int c = 0; c < MAXC; c++) begin
            dout_ready = rpat[c];
            start = (c == start_at);
            @(negedge clk);
            if (hold_v && (dout !== h_d || dout_idx !== h_i || dout_last !== h_l || dout_valid !== 1'b1))
                hold_bad++;
            hold_v = (dout_valid === 1'b1) && !dout_ready;
            h_d = dout; h_i = dout_idx; h_l = dout_last;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (core_stall !== (done_cyc < 0)) stall_bad++;
            if (dout_valid === 1'b1 && dout_ready) begin
                obs_idx.push_back(int'(dout_idx));
                obs_data.push_back(dout);
                obs_last.push_back(dout_last);
                if (int'(dout_idx) == abort_idx) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                    return;
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) begin
                @(posedge clk); #1;
                start = 1'b0; dout_ready = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rf_addr, dout, dout_idx, dout_last, dout_valid, core_stall, done} !== 46'h0) begin
            errors++;
            $display("FAIL reset_values got=%h want=0", {rf_addr, dout, dout_idx, dout_last, dout_valid, core_stall, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        regs[1] = 32'h1; regs[3] = 32'h2;
        set_pat(0);
        kick();
        drain(-1, -1);
        checks++;
        if (obs_idx.size() != NW) begin errors++; $display("FAIL basic_count got=%0d want=%0d", obs_idx.size(), NW); end
        for (int k = 0; k < obs_idx.size() && k < NW; k++) begin
            checks++;
            if (obs_idx[k] != FIRST + k || obs_data[k] !== exp_data(k) || obs_last[k] != (k == NW - 1)) begin
                errors++;
                $display("FAIL basic_word k=%0d got idx=%0d data=%h last=%0d want idx=%0d data=%h last=%0d",
                         k, obs_idx[k], obs_data[k], obs_last[k], FIRST + k, exp_data(k), (k == NW - 1));
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != exp_done()) begin
            errors++; $display("FAIL basic_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, exp_done());
        end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL basic_stall got=%0d want=0", stall_bad); end
    endtask

    task automatic test_backpressure(input int mode, input int start_at);
        fill_random();
        set_pat(mode);
        kick();
        drain(-1, start_at);
        checks++;
        if (obs_idx.size() != NW) begin errors++; $display("FAIL bp%0d_count got=%0d want=%0d", mode, obs_idx.size(), NW); end
        for (int k = 0; k < obs_idx.size() && k < NW; k++) begin
            checks++;
            if (obs_idx[k] != FIRST + k || obs_data[k] !== exp_data(k) || obs_last[k] != (k == NW - 1)) begin
                errors++;
                $display("FAIL bp%0d_word k=%0d got idx=%0d data=%h want idx=%0d data=%h",
                         mode, k, obs_idx[k], obs_data[k], FIRST + k, exp_data(k));
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != exp_done()) begin
            errors++; $display("FAIL bp%0d_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", mode, done_cnt, done_cyc, exp_done());
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL bp%0d_hold got=%0d want=0", mode, hold_bad); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL bp%0d_stall got=%0d want=0", mode, stall_bad); end
    endtask

    task automatic test_mid_start();
        test_backpressure(0, 5);
        set_pat(0);
        fill_random();
        kick();
        drain(-1, exp_done());
        checks++;
        if (done_cnt != 1 || stall_bad != 0 || obs_idx.size() != NW) begin
            errors++;
            $display("FAIL start_in_done got done=%0d stall_bad=%0d words=%0d want 1 0 %0d", done_cnt, stall_bad, obs_idx.size(), NW);
        end
    endtask

    task automatic test_x0();
        fill_random();
        regs[0] = 32'hFFFF_FFFF;
        set_pat(2);
        kick();
        drain(-1, -1);
        checks++;
        if (obs_idx.size() == 0 || obs_idx[0] != FIRST || obs_data[0] !== exp_data(0)) begin
            errors++;
            $display("FAIL x0_word got n=%0d idx=%0d data=%h want idx=%0d data=%h", obs_idx.size(),
                     (obs_idx.size() > 0) ? obs_idx[0] : -1, (obs_data.size() > 0) ? obs_data[0] : 32'h0, FIRST, exp_data(0));
        end
    endtask

    task automatic test_abort();
        fill_random();
        set_pat(0);
        kick();
        drain(10, -1);
        rst = 1'b1;
        #1;
        checks++;
        if ({rf_addr, dout, dout_idx, dout_last, dout_valid, core_stall, done} !== 46'h0) begin
            errors++;
            $display("FAIL abort_values got=%h want=0", {rf_addr, dout, dout_idx, dout_last, dout_valid, core_stall, done});
        end
        checks++;
        if (done_cnt != 0 || obs_idx.size() != 11 - FIRST) begin
            errors++; $display("FAIL abort_words got done=%0d n=%0d want 0 %0d", done_cnt, obs_idx.size(), 11 - FIRST);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        kick();
        drain(-1, -1);
        checks++;
        if (obs_idx.size() != NW || obs_idx[0] != FIRST || obs_idx[NW - 1] != NREGS - 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart got n=%0d first=%0d done=%0d want n=%0d first=%0d done=1",
                     obs_idx.size(), (obs_idx.size() > 0) ? obs_idx[0] : -1, done_cnt, NW, FIRST);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        test_reset();
        test_basic();
        test_backpressure(1, -1);
        test_backpressure(2, -1);
        test_backpressure(2, -1);
        test_mid_start();
        test_x0();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
